// File: rtl/contador_botones_param.sv
// Three-button up/down counter: each raw button is synchronised, debounced and edge-detected;
// up/down support optional long-press auto-repeat, and limit hits are flagged with a pulse.
module contador_botones_param #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned MODO_SAT   = 0,
    parameter int unsigned REP_DELAY  = 0,
    parameter int unsigned REP_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] valor,
    output logic             evt_up,
    output logic             evt_down,
    output logic             limite
);

    localparam int unsigned CW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] DEB_TERM = CW'(DEB_CYCLES - 1);
    localparam int unsigned RMAX     = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned TW       = $clog2(RMAX + 1) + 1;
    localparam logic [TW-1:0] DLY_TERM = TW'((REP_DELAY > 0) ? REP_DELAY - 1 : 0);
    localparam logic [TW-1:0] PER_TERM = TW'((REP_PERIOD > 0) ? REP_PERIOD - 1 : 0);
    localparam logic [WIDTH-1:0] MAXV  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {StReposo, StEspera, StRepite} rep_state_e;

    // Bit 0 = up, bit 1 = down, bit 2 = clear.
    logic [2:0]    raw, s1, s2, deb, deb_q, press;
    logic [CW-1:0] cnt [3];
    logic          evt_clr;
    rep_state_e    estado [2];
    logic [TW-1:0] timer [2];
    logic [1:0]    rep_evt;

    assign raw      = {btn_clr, btn_down, btn_up};
    assign press    = deb & ~deb_q;
    assign evt_up   = rep_evt[0];
    assign evt_down = rep_evt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            deb     <= '0;
            deb_q   <= '0;
            evt_clr <= 1'b0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            deb_q   <= deb;
            evt_clr <= press[2];
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_TERM) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Auto-repeat FSMs for up (0) and down (1); events are registered one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_evt <= '0;
            for (int i = 0; i < 2; i++) begin
                estado[i] <= StReposo;
                timer[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_evt[i] <= 1'b0;
                unique case (estado[i])
                    StReposo: begin
                        if (press[i]) begin
                            rep_evt[i] <= 1'b1;
                            if (REP_DELAY > 0) begin
                                estado[i] <= StEspera;
                                timer[i]  <= '0;
                            end
                        end
                    end
                    StEspera: begin
                        if (!deb[i]) begin
                            estado[i] <= StReposo;
                        end else if (timer[i] == DLY_TERM) begin
                            rep_evt[i] <= 1'b1;
                            timer[i]   <= '0;
                            estado[i]  <= StRepite;
                        end else begin
                            timer[i] <= timer[i] + TW'(1);
                        end
                    end
                    StRepite: begin
                        if (!deb[i]) begin
                            estado[i] <= StReposo;
                        end else if (timer[i] == PER_TERM) begin
                            rep_evt[i] <= 1'b1;
                            timer[i]   <= '0;
                        end else begin
                            timer[i] <= timer[i] + TW'(1);
                        end
                    end
                    default: estado[i] <= StReposo;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valor  <= '0;
            limite <= 1'b0;
        end else begin
            limite <= 1'b0;
            if (evt_clr) begin
                valor <= '0;
            end else if (evt_up && evt_down) begin
                valor <= valor;
            end else if (evt_up) begin
                if (valor == MAXV) begin
                    limite <= 1'b1;
                    if (MODO_SAT == 0) valor <= '0;
                end else begin
                    valor <= valor + WIDTH'(1);
                end
            end else if (evt_down) begin
                if (valor == '0) begin
                    limite <= 1'b1;
                    if (MODO_SAT == 0) valor <= MAXV;
                end else begin
                    valor <= valor - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_contador_botones_param.sv
// Directed bench: instance 0 defaults (wrap), 1 saturating, 2 with auto-repeat (20/5).
module tb_contador_botones_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn [3];
    logic [7:0] valor [3];
    logic       eu [3];
    logic       ed [3];
    logic       lim [3];
    int         nup [3];
    int         ndn [3];
    int         nlim [3];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    contador_botones_param u_wrap (
        .clk(clk), .rst(rst), .btn_up(btn[0][0]), .btn_down(btn[0][1]), .btn_clr(btn[0][2]),
        .valor(valor[0]), .evt_up(eu[0]), .evt_down(ed[0]), .limite(lim[0])
    );

    contador_botones_param #(.MODO_SAT(1)) u_sat (
        .clk(clk), .rst(rst), .btn_up(btn[1][0]), .btn_down(btn[1][1]), .btn_clr(btn[1][2]),
        .valor(valor[1]), .evt_up(eu[1]), .evt_down(ed[1]), .limite(lim[1])
    );

    contador_botones_param #(.REP_DELAY(20), .REP_PERIOD(5)) u_rep (
        .clk(clk), .rst(rst), .btn_up(btn[2][0]), .btn_down(btn[2][1]), .btn_clr(btn[2][2]),
        .valor(valor[2]), .evt_up(eu[2]), .evt_down(ed[2]), .limite(lim[2])
    );

    // Count cycles each pulse output is high, sampled away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (eu[i] === 1'b1) nup[i]++;
            if (ed[i] === 1'b1) ndn[i]++;
            if (lim[i] === 1'b1) nlim[i]++;
        end
    end

    // Mask bits: 0 up, 1 down, 2 clear; raw level is sampled high on 'hold' edges.
    task automatic press(input int inst, input logic [2:0] mask, input int hold);
        btn[inst] = btn[inst] | mask;
        repeat (hold) @(posedge clk);
        #1;
        btn[inst] = btn[inst] & ~mask;
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({valor[i], eu[i], ed[i], lim[i]} !== 11'd0) begin
                n_err++;
                $display("FAIL reset inst%0d: got %h want 0", i, {valor[i], eu[i], ed[i], lim[i]});
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        btn[0] = 3'b001;
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) begin
                n_vec++;
                if (eu[0] !== 1'b0) begin
                    n_err++; $display("FAIL lat_evt_e5: got %b want 0", eu[0]);
                end
            end
            if (k == 6) begin
                n_vec++;
                if (eu[0] !== 1'b1 || valor[0] !== 8'd0) begin
                    n_err++; $display("FAIL lat_e6: evt %b valor %0d want 1/0", eu[0], valor[0]);
                end
            end
            if (k == 7) begin
                n_vec++;
                if (eu[0] !== 1'b0 || valor[0] !== 8'd1) begin
                    n_err++; $display("FAIL lat_e7: evt %b valor %0d want 0/1", eu[0], valor[0]);
                end
            end
        end
        repeat (30) @(posedge clk);
        #1;
        n_vec++;
        if (nup[0] !== 1 || valor[0] !== 8'd1) begin
            n_err++; $display("FAIL held_no_repeat: nup %0d valor %0d want 1/1", nup[0], valor[0]);
        end
        btn[0] = 3'b000;
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic test_glitch();
        press(0, 3'b001, 3);
        n_vec++;
        if (nup[0] !== 1 || valor[0] !== 8'd1) begin
            n_err++; $display("FAIL glitch3: nup %0d valor %0d want 1/1", nup[0], valor[0]);
        end
        press(0, 3'b001, 4);
        n_vec++;
        if (nup[0] !== 2 || valor[0] !== 8'd2) begin
            n_err++; $display("FAIL glitch4: nup %0d valor %0d want 2/2", nup[0], valor[0]);
        end
    endtask

    task automatic test_wrap();
        press(0, 3'b010, 8);
        press(0, 3'b010, 8);
        n_vec++;
        if (valor[0] !== 8'd0 || nlim[0] !== 0) begin
            n_err++; $display("FAIL down_to_0: valor %0d lim %0d want 0/0", valor[0], nlim[0]);
        end
        press(0, 3'b010, 8);
        n_vec++;
        if (valor[0] !== 8'd255 || nlim[0] !== 1) begin
            n_err++; $display("FAIL wrap_down: valor %0d lim %0d want 255/1", valor[0], nlim[0]);
        end
        press(0, 3'b001, 8);
        n_vec++;
        if (valor[0] !== 8'd0 || nlim[0] !== 2) begin
            n_err++; $display("FAIL wrap_up: valor %0d lim %0d want 0/2", valor[0], nlim[0]);
        end
    endtask

    task automatic test_saturate();
        press(1, 3'b010, 8);
        n_vec++;
        if (valor[1] !== 8'd0 || nlim[1] !== 1) begin
            n_err++; $display("FAIL sat_down: valor %0d lim %0d want 0/1", valor[1], nlim[1]);
        end
        for (int i = 0; i < 255; i++) press(1, 3'b001, 8);
        n_vec++;
        if (valor[1] !== 8'd255 || nlim[1] !== 1) begin
            n_err++; $display("FAIL sat_climb: valor %0d lim %0d want 255/1", valor[1], nlim[1]);
        end
        press(1, 3'b001, 8);
        n_vec++;
        if (valor[1] !== 8'd255 || nlim[1] !== 2 || nup[1] !== 256) begin
            n_err++;
            $display("FAIL sat_up: valor %0d lim %0d nup %0d want 255/2/256",
                     valor[1], nlim[1], nup[1]);
        end
    endtask

    task automatic test_simultaneous();
        int u0, d0, l0;
        u0 = nup[0]; d0 = ndn[0]; l0 = nlim[0];
        press(0, 3'b011, 8);
        n_vec++;
        if (nup[0] !== u0 + 1 || ndn[0] !== d0 + 1 || valor[0] !== 8'd0 || nlim[0] !== l0) begin
            n_err++;
            $display("FAIL up_down_same: nup %0d ndn %0d valor %0d lim %0d want %0d/%0d/0/%0d",
                     nup[0], ndn[0], valor[0], nlim[0], u0 + 1, d0 + 1, l0);
        end
    endtask

    task automatic test_clear();
        int u0, l0;
        for (int i = 0; i < 37; i++) press(0, 3'b001, 8);
        n_vec++;
        if (valor[0] !== 8'd37) begin
            n_err++; $display("FAIL reach_37: got %0d want 37", valor[0]);
        end
        u0 = nup[0]; l0 = nlim[0];
        press(0, 3'b101, 8);
        n_vec++;
        if (valor[0] !== 8'd0 || nlim[0] !== l0 || nup[0] !== u0 + 1) begin
            n_err++;
            $display("FAIL clr_over_up: valor %0d lim %0d nup %0d want 0/%0d/%0d",
                     valor[0], nlim[0], nup[0], l0, u0 + 1);
        end
    endtask

    task automatic test_repeat();
        int d0;
        for (int i = 0; i < 10; i++) press(2, 3'b001, 8);
        n_vec++;
        if (valor[2] !== 8'd10) begin
            n_err++; $display("FAIL rep_setup: got %0d want 10", valor[2]);
        end
        d0 = ndn[2];
        btn[2] = 3'b010;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 7 || k == 26) begin
                n_vec++;
                if (valor[2] !== 8'd9) begin
                    n_err++; $display("FAIL rep_e%0d: got %0d want 9", k, valor[2]);
                end
            end
            if (k == 27) begin
                n_vec++;
                if (valor[2] !== 8'd8) begin
                    n_err++; $display("FAIL rep_e27: got %0d want 8", valor[2]);
                end
            end
            if (k == 59) btn[2] = 3'b000;
        end
        repeat (30) @(posedge clk);
        #1;
        // Events at edges 6, 26, 31, ..., 61; deb falls at edge 65.
        n_vec++;
        if (ndn[2] !== d0 + 9 || valor[2] !== 8'd1) begin
            n_err++;
            $display("FAIL rep_total: ndn %0d valor %0d want %0d/1", ndn[2], valor[2], d0 + 9);
        end
    endtask

    task automatic test_reset_mid();
        btn[2] = 3'b001;
        repeat (40) @(posedge clk);
        #1;
        n_vec++;
        if (valor[2] !== 8'd5) begin
            n_err++; $display("FAIL pre_rst_repite: got %0d want 5", valor[2]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++;
        if ({valor[2], eu[2], ed[2], lim[2]} !== 11'd0) begin
            n_err++; $display("FAIL mid_reset: got %h want 0", {valor[2], eu[2], ed[2], lim[2]});
        end
        for (int k = 0; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) begin
                n_vec++;
                if (valor[2] !== 8'd0 || eu[2] !== 1'b1) begin
                    n_err++; $display("FAIL rearm_e6: valor %0d evt %b want 0/1", valor[2], eu[2]);
                end
            end
            if (k == 7) begin
                n_vec++;
                if (valor[2] !== 8'd1) begin
                    n_err++; $display("FAIL rearm_e7: got %0d want 1", valor[2]);
                end
            end
        end
        btn[2] = 3'b000;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            btn[i] = 3'b000;
            nup[i] = 0;
            ndn[i] = 0;
            nlim[i] = 0;
        end
        test_reset();
        test_latency();
        test_glitch();
        test_wrap();
        test_saturate();
        test_simultaneous();
        test_clear();
        test_repeat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
